// File: rtl/snes_multi_pad_if.sv
// Connector-side and register-side signals of the multi-pad SNES reader.
// master = the reader itself, slave = the pads and the register block that drive/observe it.
interface snes_multi_pad_if #(
   parameter int NUM_PADS = 2,
   parameter int NUM_BITS = 16
);
   logic [NUM_PADS-1:0]          serial_data;
   logic                         poll_now;
   logic                         snes_clk;
   logic                         data_latch;
   logic [NUM_PADS*NUM_BITS-1:0] button_data;
   logic [NUM_PADS*NUM_BITS-1:0] button_press;
   logic                         frame_valid;
   logic                         busy;

   modport master (
      input  serial_data, poll_now,
      output snes_clk, data_latch, button_data, button_press, frame_valid, busy
   );

   modport slave (
      output serial_data, poll_now,
      input  snes_clk, data_latch, button_data, button_press, frame_valid, busy
   );
endinterface

// File: rtl/snes_multi_pad_reader.sv
// Polls NUM_PADS SNES pads on a shared snes_clk/data_latch and publishes each frame atomically.
// Optional newly-pressed detection is built when SNES_PRESS_DETECT_EN is defined.
module snes_multi_pad_reader #(
   parameter int NUM_PADS    = 2,
   parameter int NUM_BITS    = 16,
   parameter int POLL_TICKS  = 416750,
   parameter int LATCH_TICKS = 300,
   parameter int HALF_TICKS  = 150
) (
   input  logic             clk,
   input  logic             reset,
   snes_multi_pad_if.master bus
);
   localparam int TICK_MAX = (LATCH_TICKS > HALF_TICKS) ? LATCH_TICKS : HALF_TICKS;
   localparam int TW       = $clog2(TICK_MAX + 1);
   localparam int PW       = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
   localparam int IW       = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam int FW       = NUM_PADS * NUM_BITS;

   typedef enum logic [2:0] {IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE} state_t;

   state_t              state, next_state;
   logic [NUM_PADS-1:0] sync_meta, sync_data;
   logic [PW-1:0]       period_cnt;
   logic [TW-1:0]       tick_cnt;
   logic [IW-1:0]       bit_idx;
   logic [FW-1:0]       shift_reg;
   logic [FW-1:0]       frame_data;
   logic                wrap, poll_req, tick_last, last_bit;

   // Pad lines are asynchronous to clk; idle level of a line is high.
   // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= '1;
         sync_data <= '1;
      end else begin
         sync_meta <= bus.serial_data;
         sync_data <= sync_meta;
      end
   end

   assign wrap     = (period_cnt == PW'(POLL_TICKS - 1));
   assign poll_req = wrap | bus.poll_now;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         period_cnt <= '0;
      else if (wrap || bus.poll_now)
         period_cnt <= '0;
      else
         period_cnt <= period_cnt + 1'b1;
   end

   assign tick_last = (state == LATCH) ? (tick_cnt == TW'(LATCH_TICKS - 1))
                                       : (tick_cnt == TW'(HALF_TICKS - 1));
   assign last_bit  = (bit_idx == IW'(NUM_BITS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Requests arriving outside IDLE are simply not looked at, hence dropped.
   // NOTE: next_state takes a default before the case so no path can infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (poll_req)  next_state = LATCH;
         LATCH:    if (tick_last) next_state = SHIFT_LO;
         SHIFT_LO: if (tick_last) next_state = SHIFT_HI;
         SHIFT_HI: if (tick_last) next_state = last_bit ? DONE : SHIFT_LO;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt   <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         frame_data <= '0;
      end else begin
         if (state == IDLE || next_state != state)
            tick_cnt <= '0;
         else
            tick_cnt <= tick_cnt + 1'b1;

         // Cleared on the way into LATCH so a stale frame can never leak through.
         if (state == IDLE && poll_req)
            shift_reg <= '0;

         if (state == LATCH)
            bit_idx <= '0;

         if (state == SHIFT_LO && tick_last)
            for (int p = 0; p < NUM_PADS; p++)
               shift_reg[p*NUM_BITS + int'(bit_idx)] <= ~sync_data[p];

         if (state == SHIFT_HI && tick_last && !last_bit)
            bit_idx <= bit_idx + 1'b1;

         if (state == DONE)
            frame_data <= shift_reg;
      end
   end

   always_comb begin
      bus.snes_clk    = (state != SHIFT_LO);
      bus.data_latch  = (state == LATCH);
      bus.busy        = (state != IDLE);
      bus.frame_valid = (state == DONE);
   end

   assign bus.button_data = frame_data;

`ifdef SNES_PRESS_DETECT_EN
   // frame_data still holds the previous frame during DONE.
   assign bus.button_press = (state == DONE) ? (shift_reg & ~frame_data) : '0;
`else
   assign bus.button_press = '0;
`endif

endmodule

// File: tb/tb_snes_multi_pad_reader.sv
// Self-checking bench for snes_multi_pad_reader: behavioural pads, randomized frames, timing model.
module tb_snes_multi_pad_reader;
   localparam int NUM_PADS    = 2;
   localparam int NUM_BITS    = 16;
   localparam int POLL_TICKS  = 2000;
   localparam int LATCH_TICKS = 8;
   localparam int HALF_TICKS  = 4;
   localparam int FW          = NUM_PADS * NUM_BITS;
   localparam int FRAME_LEN   = 1 + LATCH_TICKS + 2 * HALF_TICKS * NUM_BITS;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   snes_multi_pad_if #(.NUM_PADS(NUM_PADS), .NUM_BITS(NUM_BITS)) bus ();

   snes_multi_pad_reader #(
      .NUM_PADS(NUM_PADS), .NUM_BITS(NUM_BITS), .POLL_TICKS(POLL_TICKS),
      .LATCH_TICKS(LATCH_TICKS), .HALF_TICKS(HALF_TICKS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Cycle number since reset release; equals the period counter until the first clear.
   int cyc;
   always @(posedge clk or posedge reset)
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;

   // Behavioural pads: load on latch, present bit 0, advance on each snes_clk rise.
   logic [NUM_BITS-1:0] pad_word [NUM_PADS];
   bit pads_on = 1'b0;
   int pad_pos = 0;

   always @(posedge bus.data_latch or posedge bus.snes_clk)
      if (bus.data_latch === 1'b1) pad_pos = 0;
      else                         pad_pos = pad_pos + 1;

   always_comb begin
      for (int p = 0; p < NUM_PADS; p++)
         bus.serial_data[p] = (pads_on && pad_pos < NUM_BITS) ? ~pad_word[p][pad_pos] : 1'b1;
   end

   // Event recorder, sampled mid-cycle.
   int   latch_rises = 0, clk_rises = 0, latch_toggles = 0, fv_pulses = 0;
   int   latch_start = 0, last_latch_width = 0;
   logic prev_clk = 1'b1, prev_latch = 1'b0;

   always @(negedge clk) begin
      if (bus.data_latch === 1'b1 && prev_latch !== 1'b1) begin
         latch_rises++;
         latch_start = cyc;
      end
      if (bus.data_latch === 1'b0 && prev_latch === 1'b1)
         last_latch_width = cyc - latch_start;
      if (bus.snes_clk === 1'b1 && prev_clk === 1'b0)
         clk_rises++;
      if (bus.data_latch === 1'b1 && bus.snes_clk !== prev_clk)
         latch_toggles++;
      if (bus.frame_valid === 1'b1)
         fv_pulses++;
      prev_clk   = bus.snes_clk;
      prev_latch = bus.data_latch;
   end

   // Reference model state: cycle at which the period counter last read 0, and the published frame.
   int            period_zero = 0;
   logic [FW-1:0] model_frame = '0;

   function automatic int next_wrap(input int now);
      int w;
      w = period_zero + POLL_TICKS - 1;
      while (w < now) w += POLL_TICKS;
      return w;
   endfunction

   function automatic logic [FW-1:0] pads_frame();
      logic [FW-1:0] f;
      f = '0;
      if (pads_on)
         for (int p = 0; p < NUM_PADS; p++)
            f[p*NUM_BITS +: NUM_BITS] = pad_word[p];
      return f;
   endfunction

   function automatic logic [FW-1:0] expected_press(input logic [FW-1:0] new_f, input logic [FW-1:0] old_f);
`ifdef SNES_PRESS_DETECT_EN
      return new_f & ~old_f;
`else
      return '0;
`endif
   endfunction

   task automatic wait_latch(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         if (bus.data_latch === 1'b1) begin
            at = cyc;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_fv(input int budget, output int at, output logic [FW-1:0] press);
      at    = -1;
      press = 'x;
      for (int i = 0; i < budget; i++) begin
         if (bus.frame_valid === 1'b1) begin
            at    = cyc;
            press = bus.button_press;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic pulse_poll(output int at);
      at = cyc;
      bus.poll_now = 1'b1;
      @(negedge clk);
      bus.poll_now = 1'b0;
      period_zero = at + 1;
   endtask

   task automatic test_reset();
      bus.poll_now = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.snes_clk !== 1'b1)   begin n_fail++; $display("FAIL reset_snes_clk: got %b, expected 1", bus.snes_clk); end
      n_checks++; if (bus.data_latch !== 1'b0) begin n_fail++; $display("FAIL reset_data_latch: got %b, expected 0", bus.data_latch); end
      n_checks++; if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
      n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b, expected 0", bus.frame_valid); end
      n_checks++; if (bus.button_data !== '0)  begin n_fail++; $display("FAIL reset_button_data: got %h, expected 0", bus.button_data); end
      n_checks++; if (bus.button_press !== '0) begin n_fail++; $display("FAIL reset_button_press: got %h, expected 0", bus.button_press); end
      reset = 1'b0;
      period_zero = 0;
   endtask

   task automatic test_idle_poll();
      int at;
      logic [FW-1:0] press;
      pads_on = 1'b0;
      wait_latch(POLL_TICKS + 100, at);
      n_checks++; if (at !== POLL_TICKS) begin n_fail++; $display("FAIL first_latch_cycle: got %0d, expected %0d", at, POLL_TICKS); end
      wait_fv(FRAME_LEN + 10, at, press);
      n_checks++; if (at !== POLL_TICKS + FRAME_LEN - 1) begin n_fail++; $display("FAIL first_fv_cycle: got %0d, expected %0d", at, POLL_TICKS + FRAME_LEN - 1); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_on_fv: got %b, expected 1", bus.busy); end
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_fv: got %b, expected 0", bus.busy); end
      n_checks++; if (bus.button_data !== '0) begin n_fail++; $display("FAIL idle_button_data: got %h, expected 0", bus.button_data); end
      model_frame = '0;
   endtask

   task automatic test_buttons();
      int at, r0, t0, exp_at;
      logic [FW-1:0] press;
      pads_on     = 1'b1;
      pad_word[0] = 16'h0009;
      pad_word[1] = 16'h0800;
      r0 = clk_rises;
      t0 = latch_toggles;
      exp_at = next_wrap(cyc) + 1;
      wait_latch(POLL_TICKS + 100, at);
      n_checks++; if (at !== exp_at) begin n_fail++; $display("FAIL auto_latch_cycle: got %0d, expected %0d", at, exp_at); end
      wait_fv(FRAME_LEN + 10, at, press);
      @(negedge clk);
      n_checks++; if (bus.button_data !== 32'h0800_0009) begin n_fail++; $display("FAIL pattern_button_data: got %h, expected 08000009", bus.button_data); end
      n_checks++; if (clk_rises - r0 !== NUM_BITS) begin n_fail++; $display("FAIL snes_clk_rises: got %0d, expected %0d", clk_rises - r0, NUM_BITS); end
      n_checks++; if (last_latch_width !== LATCH_TICKS) begin n_fail++; $display("FAIL latch_width: got %0d, expected %0d", last_latch_width, LATCH_TICKS); end
      n_checks++; if (latch_toggles - t0 !== 0) begin n_fail++; $display("FAIL clk_toggle_in_latch: got %0d, expected 0", latch_toggles - t0); end
      model_frame = pads_frame();
   endtask

   task automatic test_random_frames();
      int p_at, at;
      logic [FW-1:0] press, exp_frame, exp_press;
      for (int k = 0; k < 4; k++) begin
         for (int p = 0; p < NUM_PADS; p++) pad_word[p] = NUM_BITS'($urandom);
         repeat ($urandom_range(20, 1)) @(negedge clk);
         exp_frame = pads_frame();
         exp_press = expected_press(exp_frame, model_frame);
         pulse_poll(p_at);
         wait_latch(5, at);
         n_checks++; if (at !== p_at + 1) begin n_fail++; $display("FAIL rand_latch_cycle[%0d]: got %0d, expected %0d", k, at, p_at + 1); end
         wait_fv(FRAME_LEN + 10, at, press);
         n_checks++; if (at !== p_at + FRAME_LEN) begin n_fail++; $display("FAIL rand_fv_cycle[%0d]: got %0d, expected %0d", k, at, p_at + FRAME_LEN); end
         n_checks++; if (press !== exp_press) begin n_fail++; $display("FAIL rand_press[%0d]: got %h, expected %h", k, press, exp_press); end
         @(negedge clk);
         n_checks++; if (bus.button_data !== exp_frame) begin n_fail++; $display("FAIL rand_button_data[%0d]: got %h, expected %h", k, bus.button_data, exp_frame); end
         model_frame = exp_frame;
      end
   endtask

   task automatic test_poll_now();
      int p_at, q_at, at, lr0;
      logic [FW-1:0] press;
      repeat (5) @(negedge clk);
      lr0 = latch_rises;
      pulse_poll(p_at);
      wait_latch(5, at);
      n_checks++; if (at !== p_at + 1) begin n_fail++; $display("FAIL poll_now_latch: got %0d, expected %0d", at, p_at + 1); end
      repeat (50) @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid_frame: got %b, expected 1", bus.busy); end
      pulse_poll(q_at);
      wait_fv(FRAME_LEN + 10, at, press);
      n_checks++; if (at !== p_at + FRAME_LEN) begin n_fail++; $display("FAIL poll_now_fv: got %0d, expected %0d", at, p_at + FRAME_LEN); end
      @(negedge clk);
      n_checks++; if (latch_rises - lr0 !== 1) begin n_fail++; $display("FAIL busy_poll_dropped: got %0d latches, expected 1", latch_rises - lr0); end
      model_frame = pads_frame();
      wait_latch(POLL_TICKS + 100, at);
      n_checks++; if (at !== q_at + POLL_TICKS + 1) begin n_fail++; $display("FAIL auto_after_poll_now: got %0d, expected %0d", at, q_at + POLL_TICKS + 1); end
      wait_fv(FRAME_LEN + 10, at, press);
      @(negedge clk);
   endtask

   task automatic test_wrap_collision();
      int w, p_at, at, lr0, fv0;
      pad_word[0] = 16'hA5A5;
      pad_word[1] = 16'h5A5A;
      w = next_wrap(cyc + 2);
      for (int i = 0; i < POLL_TICKS + 10 && cyc < w; i++) @(negedge clk);
      lr0 = latch_rises;
      fv0 = fv_pulses;
      pulse_poll(p_at);
      n_checks++; if (p_at !== w) begin n_fail++; $display("FAIL wrap_align: got %0d, expected %0d", p_at, w); end
      wait_latch(5, at);
      n_checks++; if (at !== w + 1) begin n_fail++; $display("FAIL wrap_poll_latch: got %0d, expected %0d", at, w + 1); end
      repeat (300) @(negedge clk);
      n_checks++; if (latch_rises - lr0 !== 1) begin n_fail++; $display("FAIL wrap_poll_single: got %0d latches, expected 1", latch_rises - lr0); end
      n_checks++; if (fv_pulses - fv0 !== 1) begin n_fail++; $display("FAIL wrap_poll_frames: got %0d frames, expected 1", fv_pulses - fv0); end
      model_frame = pads_frame();
      n_checks++; if (bus.button_data !== model_frame) begin n_fail++; $display("FAIL wrap_button_data: got %h, expected %h", bus.button_data, model_frame); end
   endtask

   task automatic test_reset_mid_frame();
      int p_at, at, r0, fv0;
      logic [FW-1:0] press;
      r0 = clk_rises;
      pulse_poll(p_at);
      repeat (69) @(negedge clk);
      // Bit 7 high phase spans cycles p_at+69 .. p_at+72.
      n_checks++; if (bus.snes_clk !== 1'b1 || bus.busy !== 1'b1 || bus.data_latch !== 1'b0) begin
         n_fail++; $display("FAIL shift_hi_bit7: got clk=%b busy=%b latch=%b, expected 1 1 0", bus.snes_clk, bus.busy, bus.data_latch);
      end
      n_checks++; if (clk_rises - r0 !== 8) begin n_fail++; $display("FAIL rises_before_abort: got %0d, expected 8", clk_rises - r0); end
      fv0 = fv_pulses;
      reset = 1'b1;
      #1;
      n_checks++; if (bus.snes_clk !== 1'b1 || bus.data_latch !== 1'b0 || bus.busy !== 1'b0 || bus.frame_valid !== 1'b0) begin
         n_fail++; $display("FAIL abort_ctrl: got clk=%b latch=%b busy=%b fv=%b, expected 1 0 0 0", bus.snes_clk, bus.data_latch, bus.busy, bus.frame_valid);
      end
      n_checks++; if (bus.button_data !== '0) begin n_fail++; $display("FAIL abort_button_data: got %h, expected 0", bus.button_data); end
      n_checks++; if (bus.button_press !== '0) begin n_fail++; $display("FAIL abort_button_press: got %h, expected 0", bus.button_press); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      period_zero = 0;
      model_frame = '0;
      pads_on = 1'b0;
      wait_latch(POLL_TICKS + 100, at);
      n_checks++; if (at !== POLL_TICKS) begin n_fail++; $display("FAIL latch_after_abort: got %0d, expected %0d", at, POLL_TICKS); end
      n_checks++; if (fv_pulses - fv0 !== 0) begin n_fail++; $display("FAIL fv_after_abort: got %0d, expected 0", fv_pulses - fv0); end
      wait_fv(FRAME_LEN + 10, at, press);
      @(negedge clk);
      n_checks++; if (bus.button_data !== '0) begin n_fail++; $display("FAIL disconnected_data: got %h, expected 0", bus.button_data); end
   endtask

   task automatic test_press_detect();
      int p_at, at;
      logic [FW-1:0] press, exp_frame, exp_press;
      logic [NUM_BITS-1:0] seq [4];
      pads_on = 1'b1;
      seq[0] = 16'h0001;
      seq[1] = 16'h0003;
      seq[2] = NUM_BITS'($urandom);
      seq[3] = NUM_BITS'($urandom);
      for (int k = 0; k < 4; k++) begin
         pad_word[0] = seq[k];
         pad_word[1] = (k < 2) ? '0 : NUM_BITS'($urandom);
         repeat (3) @(negedge clk);
         exp_frame = pads_frame();
         exp_press = expected_press(exp_frame, model_frame);
         n_checks++; if (bus.button_press !== '0) begin n_fail++; $display("FAIL press_idle[%0d]: got %h, expected 0", k, bus.button_press); end
         pulse_poll(p_at);
         wait_fv(FRAME_LEN + 10, at, press);
         n_checks++; if (press !== exp_press) begin n_fail++; $display("FAIL press_on_fv[%0d]: got %h, expected %h", k, press, exp_press); end
         @(negedge clk);
         n_checks++; if (bus.button_press !== '0) begin n_fail++; $display("FAIL press_after_fv[%0d]: got %h, expected 0", k, bus.button_press); end
         n_checks++; if (bus.button_data !== exp_frame) begin n_fail++; $display("FAIL press_button_data[%0d]: got %h, expected %h", k, bus.button_data, exp_frame); end
         model_frame = exp_frame;
      end
   endtask

   initial begin
      pad_word[0] = '0;
      pad_word[1] = '0;
      bus.poll_now = 1'b0;
      test_reset();
      test_idle_poll();
      test_buttons();
      test_random_frames();
      test_poll_now();
      test_wrap_collision();
      test_reset_mid_frame();
      test_press_detect();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
